pwm_duty_ctrl: RTL and testbench

Duty-cycle controller and PWM generator behind the board switches and 7-segment display. It synchronises and edge-detects the on/increase/decrease switches and steps a 0–100 % duty register with clamping. It drives a glitch-free PWM output whose compare value updates only at period boundaries, and registered BCD digits for the three-digit display decoders.

---
 rtl/pwm_duty_ctrl.sv | 144 ++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ctrl.sv
// Switch-driven 0..100 % duty register with clamped stepping, PWM generator and BCD display digits.
// Latency: switch edge to duty 3 clk, duty to BCD +1 clk, en to pwm_out 3 clk; no backpressure (free-running).
module pwm_duty_ctrl #(
  parameter int DUTY_DEFAULT = 50,
  parameter int DUTY_STEP    = 10,
  parameter int PRESCALE     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  output logic [6:0] duty,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       pwm_out
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [6:0]      DEF        = 7'(DUTY_DEFAULT);
  localparam logic [7:0]      STEP       = 8'(DUTY_STEP);
  localparam logic [3:0]      DEF_H      = 4'(DUTY_DEFAULT / 100);
  localparam logic [3:0]      DEF_T      = 4'((DUTY_DEFAULT % 100) / 10);
  localparam logic [3:0]      DEF_O      = 4'(DUTY_DEFAULT % 10);

  logic en_s1, en_s2;
  logic inc_s1, inc_s2, inc_prev;
  logic dec_s1, dec_s2, dec_prev;
  logic inc_evt, dec_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_s1    <= 1'b0;
      en_s2    <= 1'b0;
      inc_s1   <= 1'b0;
      inc_s2   <= 1'b0;
      inc_prev <= 1'b0;
      dec_s1   <= 1'b0;
      dec_s2   <= 1'b0;
      dec_prev <= 1'b0;
    end else begin
      en_s1    <= en;
      en_s2    <= en_s1;
      inc_s1   <= inc;
      inc_s2   <= inc_s1;
      inc_prev <= inc_s2;
      dec_s1   <= dec;
      dec_s2   <= dec_s1;
      dec_prev <= dec_s2;
    end
  end

  assign inc_evt = inc_s2 & ~inc_prev;
  assign dec_evt = dec_s2 & ~dec_prev;

  logic [7:0] duty_sum;
  logic [7:0] duty_diff;
  logic [6:0] duty_nxt;

  assign duty_sum  = {1'b0, duty} + STEP;
  assign duty_diff = {1'b0, duty} - STEP;

  // Edges seen while disabled are dropped: the prev flops still follow the switches.
  always_comb begin
    duty_nxt = duty;
    if (!en_s2) begin
      duty_nxt = DEF;
    end else if (inc_evt && !dec_evt) begin
      duty_nxt = (duty_sum > 8'd100) ? 7'd100 : duty_sum[6:0];
    end else if (dec_evt && !inc_evt) begin
      duty_nxt = ({1'b0, duty} < STEP) ? 7'd0 : duty_diff[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) duty <= DEF;
    else     duty <= duty_nxt;
  end

  logic [PW-1:0] presc;
  logic [6:0]    phase;
  logic [6:0]    duty_act;
  logic          tick;
  logic          wrap;

  assign tick = (presc == PRESC_LAST);
  assign wrap = tick && (phase == 7'd99);

  // duty_act only moves at a period boundary or enable start, so pulses are never cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      phase    <= 7'd0;
      duty_act <= DEF;
      pwm_out  <= 1'b0;
    end else begin
      pwm_out <= en_s2 && (phase < duty_act);
      if (!en_s2) begin
        presc <= '0;
        phase <= 7'd0;
      end else if (tick) begin
        presc <= '0;
        phase <= wrap ? 7'd0 : phase + 7'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      if ((en_s1 && !en_s2) || (en_s2 && wrap))
        duty_act <= duty;
    end
  end

  logic [6:0] rem;
  logic [6:0] tens10;
  logic [3:0] hund_c, tens_c, ones_c;

  always_comb begin
    hund_c = (duty >= 7'd100) ? 4'd1 : 4'd0;
    rem    = (duty >= 7'd100) ? duty - 7'd100 : duty;
    tens_c = 4'd0;
    tens10 = 7'd0;
    for (int t = 1; t <= 9; t++) begin
      if (rem >= 7'(10 * t)) begin
        tens_c = 4'(t);
        tens10 = 7'(10 * t);
      end
    end
    ones_c = 4'(rem - tens10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_hund <= DEF_H;
      bcd_tens <= DEF_T;
      bcd_ones <= DEF_O;
    end else begin
      bcd_hund <= hund_c;
      bcd_tens <= tens_c;
      bcd_ones <= ones_c;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl at PRESCALE 1 and 4, against a history-indexed reference model
// driven by directed scenarios followed by randomized switch activity.
module tb_pwm_duty_ctrl;

  localparam int DEF  = 50;
  localparam int STEP = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, inc, dec;
  logic [6:0] duty_o [2];
  logic [3:0] hund_o [2];
  logic [3:0] tens_o [2];
  logic [3:0] ones_o [2];
  logic       pwm_o  [2];

  pwm_duty_ctrl #(.DUTY_DEFAULT(DEF), .DUTY_STEP(STEP), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec),
    .duty(duty_o[0]), .bcd_hund(hund_o[0]), .bcd_tens(tens_o[0]), .bcd_ones(ones_o[0]),
    .pwm_out(pwm_o[0])
  );

  pwm_duty_ctrl #(.DUTY_DEFAULT(DEF), .DUTY_STEP(STEP), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec),
    .duty(duty_o[1]), .bcd_hund(hund_o[1]), .bcd_tens(tens_o[1]), .bcd_ones(ones_o[1]),
    .pwm_out(pwm_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: raw switch history since reset, plus the expected outputs.
  logic [2:0] hq[$];
  int ps[2] = '{1, 4};
  int m_duty[2], m_dact[2], m_run[2], m_pwm[2], m_h[2], m_t[2], m_o[2];

  function automatic bit hb(input int idx, input int b);
    if (idx < 0) return 1'b0;
    return hq[idx][b];
  endfunction

  // Predicts the outputs after the coming rising edge from the inputs currently applied.
  task automatic model_step();
    int  n, old, ph;
    bit  e_n, e_nx, ie, de;
    if (rst) begin
      hq.delete();
      for (int i = 0; i < 2; i++) begin
        m_duty[i] = DEF; m_dact[i] = DEF; m_run[i] = 0; m_pwm[i] = 0;
        m_h[i] = DEF / 100; m_t[i] = (DEF % 100) / 10; m_o[i] = DEF % 10;
      end
    end else begin
      hq.push_back({dec, inc, en});
      n    = hq.size() - 1;
      e_n  = hb(n - 2, 0);
      e_nx = hb(n - 1, 0);
      ie   = hb(n - 2, 1) && !hb(n - 3, 1);
      de   = hb(n - 2, 2) && !hb(n - 3, 2);
      for (int i = 0; i < 2; i++) begin
        old    = m_duty[i];
        m_h[i] = old / 100;
        m_t[i] = (old % 100) / 10;
        m_o[i] = old % 10;
        ph       = (m_run[i] / ps[i]) % 100;
        m_pwm[i] = (e_n && ph < m_dact[i]) ? 1 : 0;
        if (e_n) begin
          m_run[i]++;
          if (m_run[i] % (100 * ps[i]) == 0) m_dact[i] = old;
        end else begin
          m_run[i] = 0;
        end
        if (e_nx && !e_n) m_dact[i] = old;
        if (!e_n)              m_duty[i] = DEF;
        else if (ie && !de)    m_duty[i] = (old + STEP > 100) ? 100 : old + STEP;
        else if (de && !ie)    m_duty[i] = (old < STEP) ? 0 : old - STEP;
      end
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      model_step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("duty_p%0d", ps[i]), 32'(duty_o[i]), 32'(m_duty[i]));
        check($sformatf("hund_p%0d", ps[i]), 32'(hund_o[i]), 32'(m_h[i]));
        check($sformatf("tens_p%0d", ps[i]), 32'(tens_o[i]), 32'(m_t[i]));
        check($sformatf("ones_p%0d", ps[i]), 32'(ones_o[i]), 32'(m_o[i]));
        check($sformatf("pwm_p%0d",  ps[i]), 32'(pwm_o[i]),  32'(m_pwm[i]));
      end
    end
  endtask

  task automatic count_high(input int idx, input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      run(1);
      c += int'(pwm_o[idx]);
    end
  endtask

  task automatic pulse(input bit up);
    if (up) inc = 1'b1; else dec = 1'b1;
    run(10);
    inc = 1'b0;
    dec = 1'b0;
    run(10);
  endtask

  int c;

  initial begin
    rst = 1'b1; en = 1'b0; inc = 1'b0; dec = 1'b0;
    run(3);
    check("rst_duty", 32'(duty_o[0]), 32'd50);
    check("rst_tens", 32'(tens_o[0]), 32'd5);
    check("rst_pwm",  32'(pwm_o[1]),  32'd0);
    rst = 1'b0;
    en  = 1'b1;
    run(10);
    count_high(0, 100, c); check("p1_high_50", c, 50);
    count_high(1, 400, c); check("p4_high_50", c, 200);

    pulse(1'b1); pulse(1'b1);
    check("duty_70", 32'(duty_o[0]), 32'd70);
    check("tens_70", 32'(tens_o[0]), 32'd7);
    pulse(1'b0);
    check("duty_60", 32'(duty_o[0]), 32'd60);
    run(250);

    repeat (6) pulse(1'b1);
    check("sat_100", 32'(duty_o[0]), 32'd100);
    check("hund_100", 32'(hund_o[0]), 32'd1);
    run(250);
    count_high(0, 100, c); check("p1_high_100", c, 100);
    repeat (11) pulse(1'b0);
    check("floor_0", 32'(duty_o[0]), 32'd0);
    run(250);
    count_high(0, 100, c); check("p1_high_0", c, 0);

    pulse(1'b1);
    inc = 1'b1; dec = 1'b1;
    run(10);
    inc = 1'b0; dec = 1'b0;
    run(10);
    check("both_edges", 32'(duty_o[0]), 32'd10);
    inc = 1'b1;
    run(200);
    inc = 1'b0;
    run(10);
    check("held_once", 32'(duty_o[0]), 32'd20);

    repeat (6) pulse(1'b1);
    check("duty_80", 32'(duty_o[0]), 32'd80);
    en = 1'b0;
    run(3);
    check("dis_duty", 32'(duty_o[0]), 32'd50);
    check("dis_pwm",  32'(pwm_o[0]),  32'd0);
    pulse(1'b1); pulse(1'b1);
    check("dis_ignore", 32'(duty_o[1]), 32'd50);
    en = 1'b1;
    run(20);
    count_high(0, 100, c); check("reen_high_50", c, 50);

    pulse(1'b0); pulse(1'b0);
    run(137);
    rst = 1'b1;
    run(1);
    check("midrst_duty", 32'(duty_o[0]), 32'd50);
    check("midrst_pwm",  32'(pwm_o[1]),  32'd0);
    rst = 1'b0;
    run(50);

    for (int s = 0; s < 200; s++) begin
      en  = ($urandom_range(0, 9) != 0);
      inc = 1'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      run($urandom_range(1, 25));
    end
    rst = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
